// File: rtl/mtm_riscv_soc_pkg.sv
// Shared SoC definitions used by the data bus master arbiter and its ID FIFO.
package mtm_riscv_soc_pkg;

    localparam int unsigned ARB_MAX_MASTERS          = 4;
    localparam int unsigned ARB_ID_W                 = 2;
    localparam int unsigned DATA_ARB_TIMEOUT_DEFAULT = 256;

    typedef logic [ARB_ID_W-1:0] arb_master_id_t;

    // Request-phase payload of one master, as forwarded to the slave side
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } arb_req_t;

    function automatic arb_master_id_t arb_wrap_inc(arb_master_id_t id, int unsigned n);
        return (32'(id) + 32'd1 >= n) ? arb_master_id_t'(0) : arb_master_id_t'(32'(id) + 32'd1);
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of master IDs for accepted-but-unanswered bus transactions.
module arb_id_fifo
    import mtm_riscv_soc_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  arb_master_id_t                 push_id,
    input  logic                           pop,
    output logic                           full,
    output logic                           empty,
    output arb_master_id_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    arb_master_id_t mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  cnt;
    logic           do_push;
    logic           do_pop;

    function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign head    = mem[rd_ptr];
    assign count   = cnt;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave cnt unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/data_bus_master_arbiter.sv
// Round-robin arbiter sharing the peripheral data bus, with in-order response routing.
// Optional response watchdog enabled by defining DATA_ARB_TIMEOUT_EN.
module data_bus_master_arbiter
    import mtm_riscv_soc_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned OUTSTANDING    = 2,
    parameter int unsigned TIMEOUT_CYCLES = DATA_ARB_TIMEOUT_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_MASTERS-1:0]      m_req,
    output logic [NUM_MASTERS-1:0]      m_gnt,
    input  logic [NUM_MASTERS*32-1:0]   m_addr,
    input  logic [NUM_MASTERS-1:0]      m_we,
    input  logic [NUM_MASTERS*4-1:0]    m_be,
    input  logic [NUM_MASTERS*32-1:0]   m_wdata,
    output logic [NUM_MASTERS-1:0]      m_rvalid,
    output logic                        m_err,
    output logic [31:0]                 m_rdata,
    output logic                        s_req,
    input  logic                        s_gnt,
    output logic [31:0]                 s_addr,
    output logic                        s_we,
    output logic [3:0]                  s_be,
    output logic [31:0]                 s_wdata,
    input  logic                        s_rvalid,
    input  logic                        s_err,
    input  logic [31:0]                 s_rdata
);

    localparam int unsigned CW = $clog2(OUTSTANDING + 1);

    logic [ARB_MAX_MASTERS-1:0] req_ext;
    arb_req_t                   pay [ARB_MAX_MASTERS];
    arb_req_t                   s_pay;
    arb_master_id_t             rr_ptr;
    arb_master_id_t             lock_id;
    arb_master_id_t             win_id;
    arb_master_id_t             idx;
    arb_master_id_t             fifo_head;
    logic                       lock_vld;
    logic                       found;
    logic                       hs;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [CW-1:0]              fifo_count;
    logic                       stale_zero;
    logic                       to_pop;
    logic                       rsp_pop;
    logic                       pop;

    // Unpack the flat master buses into a fixed-size payload array
    always_comb begin
        req_ext = ARB_MAX_MASTERS'(m_req);
        for (int unsigned i = 0; i < ARB_MAX_MASTERS; i++) begin
            pay[i] = '0;
        end
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            pay[i].addr  = m_addr[i*32 +: 32];
            pay[i].we    = m_we[i];
            pay[i].be    = m_be[i*4 +: 4];
            pay[i].wdata = m_wdata[i*32 +: 32];
        end
    end

    // Winner: locked master while stalled, else first requester from rr_ptr upward
    always_comb begin
        win_id = '0;
        found  = 1'b0;
        idx    = '0;
        if (lock_vld) begin
            win_id = lock_id;
            found  = req_ext[lock_id];
        end else begin
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                idx = arb_master_id_t'((32'(rr_ptr) + i) % NUM_MASTERS);
                if (!found && req_ext[idx]) begin
                    found  = 1'b1;
                    win_id = idx;
                end
            end
        end
    end

    assign s_req   = found && !fifo_full && !rst;
    assign hs      = s_req && s_gnt;
    assign s_pay   = s_req ? pay[win_id] : '0;
    assign s_addr  = s_pay.addr;
    assign s_we    = s_pay.we;
    assign s_be    = s_pay.be;
    assign s_wdata = s_pay.wdata;

    always_comb begin
        m_gnt = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            m_gnt[i] = hs && (win_id == arb_master_id_t'(i));
        end
    end

    // Round-robin pointer advances past each granted master; lock holds a stalled winner
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            lock_vld <= 1'b0;
            lock_id  <= '0;
        end else if (hs) begin
            rr_ptr   <= arb_wrap_inc(win_id, NUM_MASTERS);
            lock_vld <= 1'b0;
        end else if (s_req) begin
            lock_vld <= 1'b1;
            lock_id  <= win_id;
        end
    end

    arb_id_fifo #(
        .DEPTH   (OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (hs),
        .push_id (win_id),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head),
        .count   (fifo_count)
    );

`ifdef DATA_ARB_TIMEOUT_EN
    localparam int unsigned WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned SW  = $clog2(OUTSTANDING + 1);

    logic [WDW-1:0] wd_cnt;
    logic [SW-1:0]  stale;

    assign stale_zero = (stale == '0);
    assign to_pop     = !rst && !fifo_empty && !s_rvalid && (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));

    // Watchdog counts silent cycles; each timeout leaves one late response to discard
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            stale  <= '0;
        end else begin
            if (pop) begin
                wd_cnt <= '0;
            end else if (!fifo_empty && !s_rvalid) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (to_pop && (stale != SW'(OUTSTANDING))) begin
                stale <= stale + 1'b1;
            end else if (s_rvalid && !stale_zero) begin
                stale <= stale - 1'b1;
            end
        end
    end
`else
    assign stale_zero = 1'b1;
    assign to_pop     = 1'b0;
`endif

    assign rsp_pop = !rst && s_rvalid && !fifo_empty && stale_zero;
    assign pop     = rsp_pop || to_pop;

    // Responses go to the oldest outstanding master with no added latency
    always_comb begin
        m_rvalid = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            m_rvalid[i] = pop && (fifo_head == arb_master_id_t'(i));
        end
        m_err   = rsp_pop ? s_err   : to_pop;
        m_rdata = rsp_pop ? s_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (NUM_MASTERS >= 2 && NUM_MASTERS <= ARB_MAX_MASTERS &&
                    OUTSTANDING >= 1 && OUTSTANDING <= 4 && TIMEOUT_CYCLES >= 2)
                else $error("data_bus_master_arbiter: parameter out of range");
        end else begin
            assert (!(s_rvalid && fifo_count == '0 && stale_zero))
                else $warning("data_bus_master_arbiter: s_rvalid with nothing outstanding was dropped");
        end
    end

endmodule

// File: tb/tb_data_bus_master_arbiter.sv
// Bench for data_bus_master_arbiter: queue-based reference model plus directed scenarios.
module tb_data_bus_master_arbiter;

    localparam int N   = 2;
    localparam int OUT = 2;
    localparam int TO  = 8;
`ifdef DATA_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  m_req;
    logic [N-1:0]  m_gnt;
    logic [N*32-1:0] m_addr;
    logic [N-1:0]  m_we;
    logic [N*4-1:0] m_be;
    logic [N*32-1:0] m_wdata;
    logic [N-1:0]  m_rvalid;
    logic          m_err;
    logic [31:0]   m_rdata;
    logic          s_req;
    logic          s_gnt;
    logic [31:0]   s_addr;
    logic          s_we;
    logic [3:0]    s_be;
    logic [31:0]   s_wdata;
    logic          s_rvalid;
    logic          s_err;
    logic [31:0]   s_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_bus_master_arbiter #(
        .NUM_MASTERS    (N),
        .OUTSTANDING    (OUT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m_req    (m_req),
        .m_gnt    (m_gnt),
        .m_addr   (m_addr),
        .m_we     (m_we),
        .m_be     (m_be),
        .m_wdata  (m_wdata),
        .m_rvalid (m_rvalid),
        .m_err    (m_err),
        .m_rdata  (m_rdata),
        .s_req    (s_req),
        .s_gnt    (s_gnt),
        .s_addr   (s_addr),
        .s_we     (s_we),
        .s_be     (s_be),
        .s_wdata  (s_wdata),
        .s_rvalid (s_rvalid),
        .s_err    (s_err),
        .s_rdata  (s_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding IDs as a queue, rr pointer and lock as plain ints
    int   rr_m = 0, lk_id_m = 0, silent_m = 0, stale_m = 0, cand_m = 0;
    bit   lk_m = 1'b0;
    int   q_m[$];
    int   e_win, e_kind, e_qsz;
    bit   e_sreq, e_hs, e_rst, e_srv;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic        e_we, e_err;
    logic [3:0]  e_be;
    logic [N-1:0] e_gnt, e_rv;

    initial begin : model
        forever begin
            @(negedge clk);
            e_rst = rst; e_srv = s_rvalid; e_qsz = q_m.size();
            e_win = -1; e_kind = 0; e_sreq = 1'b0; e_hs = 1'b0;
            e_addr = '0; e_wdata = '0; e_rdata = '0; e_we = 1'b0; e_err = 1'b0;
            e_be = '0; e_gnt = '0; e_rv = '0;
            if (!rst) begin
                if (lk_m) begin
                    if (m_req[lk_id_m]) e_win = lk_id_m;
                end else begin
                    for (int i = 0; i < N; i++) begin
                        cand_m = (rr_m + i) % N;
                        if (e_win < 0 && m_req[cand_m]) e_win = cand_m;
                    end
                end
                e_sreq = (e_win >= 0) && (e_qsz < OUT);
                e_hs   = e_sreq && s_gnt;
                if (e_sreq) begin
                    e_addr  = m_addr[e_win*32 +: 32];
                    e_we    = m_we[e_win];
                    e_be    = m_be[e_win*4 +: 4];
                    e_wdata = m_wdata[e_win*32 +: 32];
                end
                if (e_hs) e_gnt = N'(1 << e_win);
                if (s_rvalid) e_kind = (stale_m > 0) ? 3 : ((e_qsz > 0) ? 1 : 4);
                else if (TO_EN && e_qsz > 0 && silent_m == TO - 1) e_kind = 2;
                if (e_kind == 1) begin
                    e_rv = N'(1 << q_m[0]); e_err = s_err; e_rdata = s_rdata;
                end else if (e_kind == 2) begin
                    e_rv = N'(1 << q_m[0]); e_err = 1'b1; e_rdata = '0;
                end
            end
            chk("s_req",    64'(s_req),    64'(e_sreq));
            chk("s_addr",   64'(s_addr),   64'(e_addr));
            chk("s_we",     64'(s_we),     64'(e_we));
            chk("s_be",     64'(s_be),     64'(e_be));
            chk("s_wdata",  64'(s_wdata),  64'(e_wdata));
            chk("m_gnt",    64'(m_gnt),    64'(e_gnt));
            chk("m_rvalid", 64'(m_rvalid), 64'(e_rv));
            chk("m_err",    64'(m_err & |m_rvalid), 64'(e_err));
            chk("m_rdata",  64'(m_rvalid != '0 ? m_rdata : 32'h0), 64'(e_rdata));
            @(posedge clk);
            if (e_rst) begin
                rr_m = 0; lk_m = 1'b0; lk_id_m = 0; silent_m = 0; stale_m = 0;
                q_m.delete();
            end else begin
                if (e_kind == 1 || e_kind == 2) begin
                    q_m.delete(0);
                    silent_m = 0;
                end else if (e_qsz > 0 && !e_srv) begin
                    silent_m++;
                end
                if (e_kind == 2 && stale_m < OUT) stale_m++;
                if (e_kind == 3) stale_m--;
                if (e_hs) begin
                    q_m.push_back(e_win);
                    rr_m = (e_win + 1) % N;
                    lk_m = 1'b0;
                end else if (e_sreq) begin
                    lk_m = 1'b1;
                    lk_id_m = e_win;
                end
            end
        end
    end

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] req, input logic gnt, input logic rv,
                         input logic err, input logic [31:0] rdata);
        m_req = req; s_gnt = gnt; s_rvalid = rv; s_err = err; s_rdata = rdata;
    endtask

    initial begin : stim
        rst     = 1'b1;
        m_addr  = {32'h2000_0004, 32'h1000_0000};
        m_we    = 2'b01;
        m_be    = {4'h3, 4'hF};
        m_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
        drive(2'b11, 1'b1, 1'b1, 1'b0, 32'h0);

        // Reset: all outputs held at zero despite active inputs
        mid();
        chk("rst_s_req", 64'(s_req), 64'h0);
        chk("rst_m_gnt", 64'(m_gnt), 64'h0);
        chk("rst_m_rvalid", 64'(m_rvalid), 64'h0);
        fin();
        rst = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        fin();

        // 1: both requesting, grants and responses alternate m0,m1
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 1'b1, k > 0, 1'b0, 32'h100 + k);
            mid();
            chk("t1_gnt", 64'(m_gnt), (k % 2) ? 64'h2 : 64'h1);
            if (k > 0) begin
                chk("t1_rvalid", 64'(m_rvalid), (k % 2) ? 64'h1 : 64'h2);
                chk("t1_rdata", 64'(m_rdata), 64'h100 + 64'(k));
            end
            fin();
        end
        drive(2'b00, 1'b0, 1'b1, 1'b0, 32'h104);
        mid(); chk("t1_last_rvalid", 64'(m_rvalid), 64'h2); fin();

        // Single m0 transaction moves the pointer to m1
        drive(2'b01, 1'b1, 1'b0, 1'b0, 32'h0);
        mid(); chk("pre2_gnt", 64'(m_gnt), 64'h1); fin();
        drive(2'b00, 1'b0, 1'b1, 1'b0, 32'h200);
        mid(); chk("pre2_rvalid", 64'(m_rvalid), 64'h1); fin();

        // 2: stalled m0 stays locked although the pointer favours m1
        drive(2'b01, 1'b0, 1'b0, 1'b0, 32'h0);
        mid();
        chk("t2_sreq", 64'(s_req), 64'h1);
        chk("t2_addr0", 64'(s_addr), 64'h1000_0000);
        fin();
        for (int k = 1; k < 3; k++) begin
            drive(2'b11, 1'b0, 1'b0, 1'b0, 32'h0);
            mid();
            chk("t2_addr_hold", 64'(s_addr), 64'h1000_0000);
            chk("t2_we_hold", 64'(s_we), 64'h1);
            fin();
        end
        drive(2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
        mid(); chk("t2_gnt_m0", 64'(m_gnt), 64'h1); fin();
        drive(2'b10, 1'b1, 1'b0, 1'b0, 32'h0);
        mid();
        chk("t2_gnt_m1", 64'(m_gnt), 64'h2);
        chk("t2_addr_m1", 64'(s_addr), 64'h2000_0004);
        chk("t2_be_m1", 64'(s_be), 64'h3);
        fin();

        // 3: FIFO full blocks the request, even in the popping cycle
        drive(2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
        mid(); chk("t3_full_sreq", 64'(s_req), 64'h0); fin();
        drive(2'b11, 1'b1, 1'b1, 1'b0, 32'h300);
        mid();
        chk("t3_pop_sreq", 64'(s_req), 64'h0);
        chk("t3_pop_rvalid", 64'(m_rvalid), 64'h1);
        fin();
        drive(2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
        mid();
        chk("t3_sreq_back", 64'(s_req), 64'h1);
        chk("t3_gnt", 64'(m_gnt), 64'h1);
        fin();
        drive(2'b00, 1'b0, 1'b1, 1'b0, 32'h301);
        mid(); chk("t3_drain_m1", 64'(m_rvalid), 64'h2); fin();
        mid(); chk("t3_drain_m0", 64'(m_rvalid), 64'h1); fin();

        // 4: error response routed to m1
        drive(2'b10, 1'b1, 1'b0, 1'b0, 32'h0);
        mid(); chk("t4_gnt", 64'(m_gnt), 64'h2); fin();
        drive(2'b00, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        mid();
        chk("t4_rvalid", 64'(m_rvalid), 64'h2);
        chk("t4_err", 64'(m_err), 64'h1);
        chk("t4_rdata", 64'(m_rdata), 64'hDEAD_BEEF);
        fin();

        // 5: reset with two outstanding, late response dropped, pointer back to m0
        drive(2'b01, 1'b1, 1'b0, 1'b0, 32'h0);
        mid(); chk("t5_gnt_a", 64'(m_gnt), 64'h1); fin();
        mid(); chk("t5_gnt_b", 64'(m_gnt), 64'h1); fin();
        rst = 1'b1;
        drive(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        mid(); chk("t5_rst_sreq", 64'(s_req), 64'h0); fin();
        rst = 1'b0;
        drive(2'b00, 1'b0, 1'b1, 1'b0, 32'h555);
        mid(); chk("t5_dropped", 64'(m_rvalid), 64'h0); fin();
        drive(2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
        mid(); chk("t5_gnt_m0", 64'(m_gnt), 64'h1); fin();
        drive(2'b00, 1'b0, 1'b1, 1'b0, 32'h500);
        mid(); chk("t5_rvalid", 64'(m_rvalid), 64'h1); fin();
        drive(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);

`ifdef DATA_ARB_TIMEOUT_EN
        // 6: silent slave times out on cycle 8; late response discarded
        drive(2'b01, 1'b1, 1'b0, 1'b0, 32'h0);
        mid(); chk("t6_gnt", 64'(m_gnt), 64'h1); fin();
        drive(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int c = 1; c <= 8; c++) begin
            mid();
            if (c < 8) begin
                chk("t6_wait", 64'(m_rvalid), 64'h0);
            end else begin
                chk("t6_to_rvalid", 64'(m_rvalid), 64'h1);
                chk("t6_to_err", 64'(m_err), 64'h1);
                chk("t6_to_rdata", 64'(m_rdata), 64'h0);
            end
            fin();
        end
        drive(2'b00, 1'b0, 1'b1, 1'b0, 32'h600);
        mid(); chk("t6_late_drop", 64'(m_rvalid), 64'h0); fin();
        drive(2'b10, 1'b1, 1'b0, 1'b0, 32'h0);
        mid(); chk("t6_gnt_m1", 64'(m_gnt), 64'h2); fin();
        drive(2'b00, 1'b0, 1'b1, 1'b0, 32'h700);
        mid();
        chk("t6_rvalid_m1", 64'(m_rvalid), 64'h2);
        chk("t6_rdata_m1", 64'(m_rdata), 64'h700);
        fin();
        drive(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
`endif

        fin();
        fin();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : guard
        #200000;
        $display("FAIL sim_timeout: bench did not complete, expected completion before %0t", $time);
        $fatal(1, "bench timeout");
    end

endmodule
